led_pattern_engine: RTL

- Parametrised successor to the fixed 6-bit rotating LED shifter.
- Integrates a prescaler, a multi-mode WIDTH-bit pattern register (rotate / Johnson / LFSR / hold, both directions), synchronous seed load, pause, and a two-digit BCD step counter.
- Drives the LED bank directly; the BCD digits feed the existing sevenSeg decoders.

---
 rtl/led_pattern_engine.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - prescaled multi-mode LED pattern register with BCD step counter
// Define PING_PONG_EN to turn mode 11 from hold into a zero-fill bounce.
module led_pattern_engine #(
    parameter int               WIDTH     = 6,
    parameter int               DIV       = 25000000,
    parameter int               DIV_W     = 25,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(6'b110000),
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(6'b000001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             pause,
    output logic [WIDTH-1:0] out_led,
    output logic             step_tick,
    output logic [3:0]       out_one,
    output logic [3:0]       out_ten,
    output logic             step_wrap
);

    logic [DIV_W-1:0] r_presc;
    logic [WIDTH-1:0] r_led;
    logic [3:0]       r_one;
    logic [3:0]       r_ten;
    logic             r_step_tick;
    logic             r_step_wrap;

    logic             w_step;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic             w_count_en;
    logic [3:0]       w_one_next;
    logic [3:0]       w_ten_next;
    logic             w_wrap;

`ifdef PING_PONG_EN
    logic             r_bdir;
    logic             w_bdir_next;
`endif

    assign w_step = (r_presc == DIV_W'(DIV - 1));
    assign w_fb   = ^(r_led & TAPS);

    always_comb begin
        w_next     = r_led;
        w_count_en = 1'b1;
`ifdef PING_PONG_EN
        w_bdir_next = r_bdir;
`endif
        case (mode)
            2'b00: w_next = dir ? {r_led[0], r_led[WIDTH-1:1]}
                                : {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            2'b01: w_next = dir ? {~r_led[0], r_led[WIDTH-1:1]}
                                : {r_led[WIDTH-2:0], ~r_led[WIDTH-1]};
            2'b10: begin
                // An all-zero LFSR would never leave zero, so reseed it with 1.
                if (r_led == '0)
                    w_next = WIDTH'(1);
                else
                    w_next = dir ? {w_fb, r_led[WIDTH-1:1]}
                                 : {r_led[WIDTH-2:0], w_fb};
            end
            default: begin
`ifdef PING_PONG_EN
                if (r_led != '0) begin
                    if (!r_bdir && r_led[WIDTH-1]) begin
                        w_bdir_next = 1'b1;
                        w_next      = r_led >> 1;
                    end else if (r_bdir && r_led[0]) begin
                        w_bdir_next = 1'b0;
                        w_next      = r_led << 1;
                    end else begin
                        w_next = r_bdir ? (r_led >> 1) : (r_led << 1);
                    end
                end
`else
                w_count_en = 1'b0;
`endif
            end
        endcase
    end

    always_comb begin
        w_one_next = r_one + 4'd1;
        w_ten_next = r_ten;
        w_wrap     = 1'b0;
        if (r_one == 4'd9) begin
            w_one_next = 4'd0;
            if (r_ten == 4'd9) begin
                w_ten_next = 4'd0;
                w_wrap     = 1'b1;
            end else begin
                w_ten_next = r_ten + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_led       <= RESET_VAL;
            r_one       <= 4'd0;
            r_ten       <= 4'd0;
            r_step_tick <= 1'b0;
            r_step_wrap <= 1'b0;
`ifdef PING_PONG_EN
            r_bdir      <= 1'b0;
`endif
        end else if (load) begin
            r_presc     <= '0;
            r_led       <= seed;
            r_one       <= 4'd0;
            r_ten       <= 4'd0;
            r_step_tick <= 1'b0;
            r_step_wrap <= 1'b0;
`ifdef PING_PONG_EN
            r_bdir      <= dir;
`endif
        end else if (pause) begin
            r_step_tick <= 1'b0;
            r_step_wrap <= 1'b0;
        end else begin
            r_step_tick <= w_step;
            r_step_wrap <= 1'b0;
            if (w_step) begin
                r_presc <= '0;
                r_led   <= w_next;
`ifdef PING_PONG_EN
                r_bdir  <= w_bdir_next;
`endif
                if (w_count_en) begin
                    r_one       <= w_one_next;
                    r_ten       <= w_ten_next;
                    r_step_wrap <= w_wrap;
                end
            end else begin
                r_presc <= r_presc + DIV_W'(1);
            end
        end
    end

    assign out_led   = r_led;
    assign step_tick = r_step_tick;
    assign out_one   = r_one;
    assign out_ten   = r_ten;
    assign step_wrap = r_step_wrap;

endmodule
